// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding encodings and default sizes for hazard control
// Contents:
//   fwd_sel_e  operand source select used by the forwarding logic and the EX operand muxes
//   DEF_*      default register-file and counter sizes
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   localparam int DEF_RAW   = 5;
   localparam int DEF_NREGS = 32;
   localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/hazard_fwd_scoreboard_if.sv
// rtl/hazard_fwd_scoreboard_if.sv - pipeline-side signal bundle of the hazard/forwarding block
// Signals:
//   ID stage   rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, regwrite_id
//   EX stage   rs1_ex, rs2_ex, rd_ex, regwrite_ex, memread_ex
//   MEM / WB   rd_mem, regwrite_mem, rd_wb, regwrite_wb
//   MC unit    mc_issue, mc_rd, mc_done, mc_done_rd
//   control    flush
//   results    forward_a, forward_b, stall, pending, stall_cycles
// Modports: master = pipeline driving the block, slave = the hazard block itself.
interface hazard_fwd_scoreboard_if
   import hazard_pkg::*;
#(
   parameter int RAW   = DEF_RAW,
   parameter int NREGS = DEF_NREGS,
   parameter int CNT_W = DEF_CNT_W
);
   logic [RAW-1:0]   rs1_id;
   logic [RAW-1:0]   rs2_id;
   logic             rs1_used_id;
   logic             rs2_used_id;
   logic [RAW-1:0]   rd_id;
   logic             regwrite_id;
   logic [RAW-1:0]   rs1_ex;
   logic [RAW-1:0]   rs2_ex;
   logic [RAW-1:0]   rd_ex;
   logic             regwrite_ex;
   logic             memread_ex;
   logic [RAW-1:0]   rd_mem;
   logic             regwrite_mem;
   logic [RAW-1:0]   rd_wb;
   logic             regwrite_wb;
   logic             mc_issue;
   logic [RAW-1:0]   mc_rd;
   logic             mc_done;
   logic [RAW-1:0]   mc_done_rd;
   logic             flush;
   logic [1:0]       forward_a;
   logic [1:0]       forward_b;
   logic             stall;
   logic [NREGS-1:0] pending;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, regwrite_id,
      output rs1_ex, rs2_ex, rd_ex, regwrite_ex, memread_ex,
      output rd_mem, regwrite_mem, rd_wb, regwrite_wb,
      output mc_issue, mc_rd, mc_done, mc_done_rd, flush,
      input  forward_a, forward_b, stall, pending, stall_cycles
   );

   modport slave (
      input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_id, regwrite_id,
      input  rs1_ex, rs2_ex, rd_ex, regwrite_ex, memread_ex,
      input  rd_mem, regwrite_mem, rd_wb, regwrite_wb,
      input  mc_issue, mc_rd, mc_done, mc_done_rd, flush,
      output forward_a, forward_b, stall, pending, stall_cycles
   );

endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register outstanding-write scoreboard for the multicycle unit
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   set_en, set_idx          mark a register as having an in-flight multicycle write
//   clr_en, clr_idx          multicycle write-back completing this cycle
//   rs1/rs2/rd_idx           lookup indices from the ID stage
//   rs1/rs2/rd_pend          lookup results, with this cycle's completion already removed
//   pend                     raw scoreboard vector
module reg_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int RAW   = DEF_RAW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set_en,
   input  logic [RAW-1:0]   set_idx,
   input  logic             clr_en,
   input  logic [RAW-1:0]   clr_idx,
   input  logic [RAW-1:0]   rs1_idx,
   input  logic [RAW-1:0]   rs2_idx,
   input  logic [RAW-1:0]   rd_idx,
   output logic             rs1_pend,
   output logic             rs2_pend,
   output logic             rd_pend,
   output logic [NREGS-1:0] pend
);

   logic [NREGS-1:0] pend_q;
   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] clr_mask;
   logic [NREGS-1:0] visible;

   // Decoders start at 1 so x0 can never be set or matched; indices at or
   // above NREGS simply decode to nothing.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int i = 1; i < NREGS; i++) begin
         if (set_en && set_idx == RAW'(i)) set_mask[i] = 1'b1;
         if (clr_en && clr_idx == RAW'(i)) clr_mask[i] = 1'b1;
      end
   end

   // A write completing this cycle is forwarded from WB next cycle, so it
   // must not hold the ID instruction back.
   assign visible = pend_q & ~clr_mask;

   always_comb begin
      rs1_pend = 1'b0;
      rs2_pend = 1'b0;
      rd_pend  = 1'b0;
      for (int i = 1; i < NREGS; i++) begin
         if (rs1_idx == RAW'(i)) rs1_pend = visible[i];
         if (rs2_idx == RAW'(i)) rs2_pend = visible[i];
         if (rd_idx  == RAW'(i)) rd_pend  = visible[i];
      end
   end

   // Set is applied after clear: a same-index issue is younger than the
   // completing op and must stay tracked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= visible | set_mask;
      end
   end

   assign pend = pend_q;

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// rtl/hazard_fwd_scoreboard.sv - EX forwarding select, load-use and scoreboard stall, stall counter
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   bus        slave side of hazard_fwd_scoreboard_if (pipeline stage fields in,
//              forward_a/forward_b/stall/pending/stall_cycles out)
module hazard_fwd_scoreboard
   import hazard_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int RAW   = DEF_RAW,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   hazard_fwd_scoreboard_if.slave bus
);

   fwd_sel_e         fwd_a;
   fwd_sel_e         fwd_b;
   logic             load_use;
   logic             sb_hazard;
   logic             stall;
   logic             rs1_pend;
   logic             rs2_pend;
   logic             rd_pend;
   logic             sb_set;
   logic [NREGS-1:0] pend;
   logic [CNT_W-1:0] cnt_q;

   // MEM holds the younger result, so it takes priority over WB.
   function automatic fwd_sel_e fwd_select(
      input logic [RAW-1:0] rs,
      input logic           wr_mem,
      input logic [RAW-1:0] dst_mem,
      input logic           wr_wb,
      input logic [RAW-1:0] dst_wb
   );
      if (wr_mem && dst_mem != '0 && dst_mem == rs) return FWD_MEM;
      if (wr_wb  && dst_wb  != '0 && dst_wb  == rs) return FWD_WB;
      return FWD_RF;
   endfunction

   always_comb begin
      fwd_a = fwd_select(bus.rs1_ex, bus.regwrite_mem, bus.rd_mem, bus.regwrite_wb, bus.rd_wb);
      fwd_b = fwd_select(bus.rs2_ex, bus.regwrite_mem, bus.rd_mem, bus.regwrite_wb, bus.rd_wb);
   end

   assign sb_set = bus.mc_issue && bus.mc_rd != '0;

   reg_scoreboard #(
      .NREGS (NREGS),
      .RAW   (RAW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (sb_set),
      .set_idx  (bus.mc_rd),
      .clr_en   (bus.mc_done),
      .clr_idx  (bus.mc_done_rd),
      .rs1_idx  (bus.rs1_id),
      .rs2_idx  (bus.rs2_id),
      .rd_idx   (bus.rd_id),
      .rs1_pend (rs1_pend),
      .rs2_pend (rs2_pend),
      .rd_pend  (rd_pend),
      .pend     (pend)
   );

   assign load_use = bus.memread_ex && bus.rd_ex != '0 &&
                     ((bus.rs1_used_id && bus.rs1_id == bus.rd_ex) ||
                      (bus.rs2_used_id && bus.rs2_id == bus.rd_ex));

   // RAW on either source, or WAW on the destination against an in-flight MC write.
   assign sb_hazard = (bus.rs1_used_id && rs1_pend) ||
                      (bus.rs2_used_id && rs2_pend) ||
                      (bus.regwrite_id && rd_pend);

   // The flushed ID instruction is discarded anyway, so holding it is pointless.
   assign stall = (load_use || sb_hazard) && !bus.flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (stall && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.forward_a    = fwd_a;
   assign bus.forward_b    = fwd_b;
   assign bus.stall        = stall;
   assign bus.pending      = pend;
   assign bus.stall_cycles = cnt_q;

endmodule
